// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one full-subtractor step
// per clock, LSB first, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             bit_d, bit_br;

  always_comb begin
    bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
    bit_br   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    state_d  = state_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sr_d  = {bit_d, sr_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = bit_br;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = {bit_d, sr_q[WIDTH-1:1]};
          borrow_d = bit_br;
          // On the final step sa_q[0]/sb_q[0] are the operand sign bits.
          ovf_d    = (sa_q[0] ^ sb_q[0]) & (bit_d ^ sa_q[0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand/result shifters need no reset: they are always reloaded before use.
  always_ff @(posedge clk) begin
    sa_q <= sa_d;
    sb_q <= sb_d;
    sr_q <= sr_d;
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_serial_subtractor;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_i = '0, b_i = '0;
  logic             busy, done, borrow, overflow;
  logic [WIDTH-1:0] diff;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-cycle count and arithmetic results.
  int               m_rem = 0;
  logic             m_done = 1'b0;
  logic             m_ok = 1'b0;
  logic [WIDTH-1:0] m_a, m_b;
  logic [WIDTH-1:0] e_diff = '0;
  logic             e_bor = 1'b0, e_ovf = 1'b0;
  longint           r;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_rem = 0; m_done = 1'b0; e_diff = '0; e_bor = 1'b0; e_ovf = 1'b0; m_ok = 1'b1;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_a = a_i; m_b = b_i; m_rem = WIDTH;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        e_diff = m_a - m_b;
        e_bor  = (m_a < m_b);
        r      = longint'($signed(m_a)) - longint'($signed(m_b));
        e_ovf  = (r > 32767) || (r < -32768);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (m_ok)
      chk("model", {12'd0, busy, done, diff, borrow, overflow},
          {12'd0, (m_rem != 0), m_done, e_diff, e_bor, e_ovf});
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                    input string name);
    int lat;
    start = 1'b1; a_i = a; b_i = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk({name, "_lat"}, lat, 17);
    chk({name, "_res"}, {14'd0, diff, borrow, overflow}, {14'd0, ed, eb, eo});
    @(negedge clk);
    chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, t0, t1, n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", {13'd0, busy, done, diff, borrow, overflow}, 32'd0);

    op(16'd5, 16'd3, 16'h0002, 1'b0, 1'b0, "5m3");
    op(16'd3, 16'd5, 16'hFFFE, 1'b1, 1'b0, "3m5");
    op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "min_m1");
    op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, "max_mneg1");

    // Start while busy is ignored; operands change freely after capture.
    start = 1'b1; a_i = 16'd10; b_i = 16'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a_i = 16'd1; b_i = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
      @(negedge clk);
    end
    wait_done(lat);
    chk("ignored_res", {15'd0, diff, borrow}, {15'd0, 16'h0006, 1'b0});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("ignored_single_done", n, 0);

    // Continuous start: back-to-back every WIDTH+1 cycles.
    start = 1'b1; a_i = 16'h0000; b_i = 16'h0000;
    @(negedge clk);
    wait_done(lat); t0 = cyc;
    chk("b2b_zero", {15'd0, diff, borrow}, 32'd0);
    a_i = 16'hFFFF; b_i = 16'hFFFF;
    @(negedge clk);
    wait_done(lat); t1 = cyc;
    chk("b2b_interval", t1 - t0, 17);
    @(negedge clk);
    wait_done(lat); t0 = cyc;
    chk("b2b_ffff", {15'd0, diff, borrow}, 32'd0);
    chk("b2b_interval2", t0 - t1, 17);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    start = 1'b1; a_i = 16'd9; b_i = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort", {14'd0, busy, done, diff}, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);
    op(16'd9, 16'd2, 16'h0007, 1'b0, 1'b0, "after_rst");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
